// File: rtl/code_sel_gen.sv
// code_sel_gen: debounced 3-bit code selector for a 3-8 decoder, with optional auto-scan.
// Latency: a stable switch change reaches code DEB_CYCLES+2 cycles after it is first sampled.
// Backpressure: none; free-running, all inputs sampled every cycle, all outputs registered.
// Ports: clk, rst (sync, active-high), sw_raw[2:0], btn_mode -> code[2:0], enable[2:0], auto_mode.
// Optional feature macro: CODE_SEL_AUTO_SCAN_EN enables the AUTO state, step counter and mode button.
module code_sel_gen #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int STEP_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_raw,
    input  logic       btn_mode,
    output logic [2:0] code,
    output logic [2:0] enable,
    output logic       auto_mode
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);

    // ---------------- switch synchronizer + debouncer ----------------
    logic [2:0]    sw_s1, sw_s2, sw_cand, sw_deb;
    logic [DW-1:0] sw_cnt, sw_cnt_nxt;
    logic          sw_acc_nxt, sw_acc;

    // sw_cnt = number of consecutive samples equal to sw_cand, saturating at DEB_MAX.
    // Acceptance fires once, on the sample that brings the run to exactly DEB_MAX.
    always_comb begin
        sw_cnt_nxt = sw_cnt;
        if (sw_s2 != sw_cand)
            sw_cnt_nxt = DW'(1);
        else if (sw_cnt != DEB_MAX)
            sw_cnt_nxt = sw_cnt + 1'b1;
        sw_acc_nxt = (sw_cnt_nxt == DEB_MAX) && ((sw_s2 != sw_cand) || (sw_cnt != DEB_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1   <= 3'b000;
            sw_s2   <= 3'b000;
            sw_cand <= 3'b000;
            sw_deb  <= 3'b000;
            sw_cnt  <= '0;
            sw_acc  <= 1'b0;
        end else begin
            sw_s1   <= sw_raw;
            sw_s2   <= sw_s1;
            sw_cand <= sw_s2;
            sw_cnt  <= sw_cnt_nxt;
            sw_acc  <= sw_acc_nxt;
            if (sw_acc_nxt)
                sw_deb <= sw_s2;
        end
    end

`ifdef CODE_SEL_AUTO_SCAN_EN
    // ---------------- mode button synchronizer + debouncer ----------------
    logic          b_s1, b_s2, b_cand, b_deb, mode_ev;
    logic [DW-1:0] b_cnt, b_cnt_nxt;
    logic          b_acc_nxt;

    always_comb begin
        b_cnt_nxt = b_cnt;
        if (b_s2 != b_cand)
            b_cnt_nxt = DW'(1);
        else if (b_cnt != DEB_MAX)
            b_cnt_nxt = b_cnt + 1'b1;
        b_acc_nxt = (b_cnt_nxt == DEB_MAX) && ((b_s2 != b_cand) || (b_cnt != DEB_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_s1    <= 1'b0;
            b_s2    <= 1'b0;
            b_cand  <= 1'b0;
            b_deb   <= 1'b0;
            b_cnt   <= '0;
            mode_ev <= 1'b0;
        end else begin
            b_s1    <= btn_mode;
            b_s2    <= b_s1;
            b_cand  <= b_s2;
            b_cnt   <= b_cnt_nxt;
            // only a debounced rising edge is a mode event
            mode_ev <= b_acc_nxt && b_s2 && !b_deb;
            if (b_acc_nxt)
                b_deb <= b_s2;
        end
    end

    // ---------------- step counter ----------------
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MANUAL = 2'd1, AUTO = 2'd2} state_t;
    state_t        state, state_nxt;
    logic [SW-1:0] step_cnt;
    logic          step_tick;

    assign step_tick = (state == AUTO) && (step_cnt == STEP_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sw_acc)  state_nxt = MANUAL;
            MANUAL:  if (mode_ev) state_nxt = AUTO;
            AUTO:    if (mode_ev) state_nxt = MANUAL;
            default: state_nxt = IDLE;
        endcase
    end

    logic [2:0] code_nxt, enable_nxt;
    logic       auto_nxt;

    // A mode event leaves state_nxt != AUTO, so it always beats a coincident step tick.
    always_comb begin
        code_nxt = code;
        case (state_nxt)
            MANUAL:  code_nxt = sw_deb;
            AUTO:    if (step_tick) code_nxt = code + 1'b1;
            default: code_nxt = code;
        endcase
        enable_nxt = (state_nxt == IDLE) ? 3'b000 : 3'b100;
        auto_nxt   = (state_nxt == AUTO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code      <= 3'b000;
            enable    <= 3'b000;
            auto_mode <= 1'b0;
            step_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            code      <= code_nxt;
            enable    <= enable_nxt;
            auto_mode <= auto_nxt;
            // cleared on entry, on exit and on every tick; counts only while staying in AUTO
            if (state != AUTO || state_nxt != AUTO || step_tick)
                step_cnt <= '0;
            else
                step_cnt <= step_cnt + 1'b1;
        end
    end
`else
    // Button is kept on the port list but has no function in this build.
    logic btn_unused;
    assign btn_unused = btn_mode;

    typedef enum logic {IDLE = 1'b0, MANUAL = 1'b1} state_t;
    state_t     state, state_nxt;
    logic [2:0] code_nxt, enable_nxt;

    always_comb begin
        state_nxt = state;
        if (state == IDLE && sw_acc)
            state_nxt = MANUAL;
    end

    always_comb begin
        code_nxt   = (state_nxt == MANUAL) ? sw_deb : code;
        enable_nxt = (state_nxt == IDLE) ? 3'b000 : 3'b100;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            code   <= 3'b000;
            enable <= 3'b000;
        end else begin
            state  <= state_nxt;
            code   <= code_nxt;
            enable <= enable_nxt;
        end
    end

    assign auto_mode = 1'b0;
`endif

endmodule

// File: doc/code_sel_gen.md
CODE_SEL_GEN -- requirements
Module: code_sel_gen

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000: consecutive stable cycles required to accept an input change (10 ms at 100 MHz); legal range >= 1.
REQ-002 SHALL have parameter STEP_CYCLES, default 50000000: cycles per auto-scan step; legal range >= 1.
REQ-003 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port sw_raw  input  3: raw, asynchronous board switches.
REQ-006 SHALL have port btn_mode  input  1: raw, asynchronous mode button, active-high.
REQ-007 SHALL have port code  output  3: selected code, registered; this is the 3-8 decoder's switch input.
REQ-008 SHALL have port enable  output  3: decoder enable, registered; 3'b100 when active, 3'b000 otherwise.
REQ-009 SHALL have port auto_mode  output  1: registered; 1 while in AUTO state.

Function
REQ-010 SHALL pass each of sw_raw and btn_mode through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce the synchronized 3-bit switch vector as a unit.
- Any bit change restarts the stability counter.
- New value is accepted after DEB_CYCLES consecutive equal synchronized samples.
REQ-012 SHALL update code on the edge exactly DEB_CYCLES+2 cycles after a raw change first sampled, if held stable throughout.
- Glitches shorter than DEB_CYCLES SHALL never reach code.
REQ-013 SHALL debounce btn_mode identically, with its own counter; a mode event is the debounced 0->1 transition only, a single-cycle internal pulse.
REQ-014 SHALL implement states IDLE, MANUAL, AUTO.
- IDLE -> MANUAL on first debounced switch acceptance, including acceptance of the reset value 3'b000.
- MANUAL -> AUTO on mode event.
- AUTO -> MANUAL on mode event.
- IDLE ignores mode events.
REQ-015 SHALL drive enable = 3'b000 in IDLE and 3'b100 in MANUAL and AUTO.
REQ-016 In MANUAL, code SHALL follow the debounced switch value.
REQ-017 In AUTO, code SHALL increment by 1 every STEP_CYCLES cycles, wrapping modulo 8 (7 -> 0).
- Switch acceptances SHALL still be tracked but SHALL NOT drive code.
REQ-018 On entry to AUTO, code SHALL hold its current value and the step counter SHALL clear; first increment occurs STEP_CYCLES cycles after entry.
REQ-019 On return to MANUAL, code SHALL take the current debounced switch value on the next edge.
REQ-020 If a mode event and a step tick coincide, the mode change SHALL win: no increment, step counter cleared.
REQ-021 Counter widths SHALL be $clog2 of their limits, rounded up; counters SHALL saturate or clear, never wrap silently.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL set:
- code=3'b000, enable=3'b000, auto_mode=0, state=IDLE;
- all counters 0;
- synchronizer and debounced registers 3'b000 / 0.
REQ-023 Reset asserted mid-debounce or mid-step SHALL discard the pending operation; there is no asynchronous path.

Configuration
REQ-024 Macro CODE_SEL_AUTO_SCAN_EN defined: AUTO state, step counter and btn_mode logic SHALL be present as specified.
REQ-025 Macro CODE_SEL_AUTO_SCAN_EN undefined: AUTO state and step counter SHALL be absent.
- btn_mode remains a port but is ignored.
- auto_mode is tied 0.
- Block is IDLE/MANUAL only.

Verification (DEB_CYCLES=4, STEP_CYCLES=8, macro defined unless noted)
REQ-026 Reset, then sw_raw=3'b101 held -> code=3'b101 and enable=3'b100 exactly 6 cycles after first sampling; enable=3'b000 before that.
REQ-027 In MANUAL with code=3'b101, sw_raw pulses to 3'b010 for 3 cycles then returns -> code stays 3'b101, no enable drop.
REQ-028 In MANUAL with code=3'b110, btn_mode held high -> auto_mode=1, then code 6,7,0,1 at 8-cycle intervals (wrap checked).
REQ-029 Mode event on the same cycle as a step tick -> state MANUAL, no increment; code becomes the debounced switch value on the next edge.
REQ-030 rst asserted for 1 cycle mid-AUTO -> code=0, enable=3'b000, auto_mode=0 next edge; requires a fresh debounce to re-enable.
REQ-031 Macro undefined: btn_mode toggled repeatedly -> auto_mode=0 and code tracks switches only.
